// File: rtl/run_sequencer.sv
// Host-side initiator for the DUT Reset/Start/Ack handshake: runs up to 2**RUN_W
// programs back to back, timing each from Start to Ack and flagging timeouts.
module run_sequencer #(
  parameter int              RUN_W     = 2,
  parameter int              CW        = 16,
  parameter logic [CW-1:0]   TIMEOUT   = 16'hFFFF,
  parameter int              RST_CYC   = 2,
  parameter int              START_CYC = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             go,
  input  logic [RUN_W-1:0] num_runs,
  input  logic             dut_ack,
  output logic             dut_reset,
  output logic             dut_start,
  output logic [RUN_W-1:0] prog_sel,
  output logic             busy,
  output logic             result_valid,
  output logic [RUN_W-1:0] result_run,
  output logic [CW-1:0]    result_cycles,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    IDLE,
    RST,
    STRT,
    RUN,
    REPORT,
    FIN
  } state_t;

  localparam logic [CW-1:0] RstLast   = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] StartLast = CW'(START_CYC - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [RUN_W-1:0] lastRun;

  // cnt is shared: phase length in RST/STRT, elapsed cycles in RUN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      lastRun       <= '0;
      dut_reset     <= 1'b0;
      dut_start     <= 1'b0;
      prog_sel      <= '0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      result_run    <= '0;
      result_cycles <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            lastRun   <= num_runs;
            error     <= 1'b0;
            prog_sel  <= '0;
            busy      <= 1'b1;
            dut_reset <= 1'b1;
            cnt       <= '0;
            state     <= RST;
          end
        end
        RST: begin
          if (cnt == RstLast) begin
            dut_reset <= 1'b0;
            dut_start <= 1'b1;
            cnt       <= '0;
            state     <= STRT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STRT: begin
          // Ack here is left over from the previous program and is ignored
          if (cnt == StartLast) begin
            dut_start <= 1'b0;
            cnt       <= '0;
            state     <= RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (dut_ack) begin
            result_cycles <= cnt;
            result_run    <= prog_sel;
            result_valid  <= 1'b1;
            state         <= REPORT;
          end else if (cnt == TIMEOUT) begin
            result_cycles <= TIMEOUT;
            result_run    <= prog_sel;
            result_valid  <= 1'b1;
            error         <= 1'b1;
            state         <= REPORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPORT: begin
          if (error || prog_sel == lastRun) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            prog_sel  <= prog_sel + 1'b1;
            dut_reset <= 1'b1;
            cnt       <= '0;
            state     <= RST;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized bench for run_sequencer: a per-cycle expected trace is built from the
// handshake timing rules and compared with the sampled outputs.
module tb_run_sequencer;

  localparam int RUN_W     = 2;
  localparam int CW        = 16;
  localparam int RST_CYC   = 2;
  localparam int START_CYC = 1;
  localparam int TMO       = 20;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             go;
  logic [RUN_W-1:0] num_runs;
  logic             dut_ack;
  logic             dut_reset;
  logic             dut_start;
  logic [RUN_W-1:0] prog_sel;
  logic             busy;
  logic             result_valid;
  logic [RUN_W-1:0] result_run;
  logic [CW-1:0]    result_cycles;
  logic             done;
  logic             error;

  always #5 Clk = ~Clk;

  run_sequencer #(
    .RUN_W(RUN_W), .CW(CW), .TIMEOUT(16'(TMO)), .RST_CYC(RST_CYC), .START_CYC(START_CYC)
  ) dut (
    .Clk(Clk), .Reset(Reset), .go(go), .num_runs(num_runs), .dut_ack(dut_ack),
    .dut_reset(dut_reset), .dut_start(dut_start), .prog_sel(prog_sel), .busy(busy),
    .result_valid(result_valid), .result_run(result_run), .result_cycles(result_cycles),
    .done(done), .error(error)
  );

  typedef struct packed {
    logic        rst;
    logic        strt;
    logic        busy;
    logic        rv;
    logic        done;
    logic        err;
    logic [1:0]  sel;
    logic [1:0]  run;
    logic [15:0] cyc;
  } outs_t;

  outs_t expQ[$];
  outs_t obsQ[$];
  logic  goQ[$];
  logic  ackQ[$];

  int total = 0;
  int bad   = 0;

  // Values that hold between events (prog_sel, result_*, error)
  logic [1:0]  hSel = '0;
  logic [1:0]  hRun = '0;
  logic [15:0] hCyc = '0;
  logic        hErr = 1'b0;

  function automatic outs_t cur(input logic b);
    outs_t o;
    o      = '0;
    o.busy = b;
    o.sel  = hSel;
    o.run  = hRun;
    o.cyc  = hCyc;
    o.err  = hErr;
    return o;
  endfunction

  function automatic logic noise(input logic en);
    return en ? 1'($urandom) : 1'b0;
  endfunction

  // Expected trace: entry c is what the outputs show during cycle c, and the
  // go/ack entries are the inputs seen by the edge that ends that cycle.
  function automatic void build(input int nr, input int d [4], input logic ackPre,
                                input logic noisyGo);
    outs_t o;
    int    res;
    logic  ab;
    expQ.delete(); goQ.delete(); ackQ.delete();
    expQ.push_back(cur(1'b0)); goQ.push_back(1'b1); ackQ.push_back(1'($urandom));
    hSel = '0;
    hErr = 1'b0;
    for (int k = 0; k <= nr; k++) begin
      hSel = 2'(k);
      for (int i = 0; i < RST_CYC; i++) begin
        o = cur(1'b1); o.rst = 1'b1;
        expQ.push_back(o); goQ.push_back(noise(noisyGo)); ackQ.push_back(ackPre);
      end
      for (int i = 0; i < START_CYC; i++) begin
        o = cur(1'b1); o.strt = 1'b1;
        expQ.push_back(o); goQ.push_back(noise(noisyGo)); ackQ.push_back(ackPre);
      end
      res = 0;
      ab  = 1'b0;
      for (int j = 0; j <= TMO; j++) begin
        expQ.push_back(cur(1'b1)); goQ.push_back(noise(noisyGo));
        ackQ.push_back(j >= d[k]);
        if (j >= d[k]) begin
          res = j;
          break;
        end
        if (j == TMO) begin
          res = TMO;
          ab  = 1'b1;
        end
      end
      hRun = 2'(k);
      hCyc = 16'(res);
      hErr = ab;
      o = cur(1'b1); o.rv = 1'b1;
      expQ.push_back(o); goQ.push_back(noise(noisyGo)); ackQ.push_back(1'($urandom));
      if (ab || k == nr) begin
        o = cur(1'b1); o.done = 1'b1;
        expQ.push_back(o); goQ.push_back(noise(noisyGo)); ackQ.push_back(1'($urandom));
        break;
      end
    end
    expQ.push_back(cur(1'b0)); goQ.push_back(1'b0); ackQ.push_back(1'($urandom));
  endfunction

  task automatic play(input logic [1:0] nr, input int maxC);
    outs_t o;
    obsQ.delete();
    for (int c = 0; c < expQ.size() && c < maxC; c++) begin
      @(negedge Clk);
      o.rst  = dut_reset;
      o.strt = dut_start;
      o.busy = busy;
      o.rv   = result_valid;
      o.done = done;
      o.err  = error;
      o.sel  = prog_sel;
      o.run  = result_run;
      o.cyc  = result_cycles;
      obsQ.push_back(o);
      go       = goQ[c];
      num_runs = (c == 0) ? nr : 2'($urandom);
      dut_ack  = ackQ[c];
    end
  endtask

  task automatic test_reset();
    outs_t o;
    Reset = 1'b1; go = 1'b1; num_runs = 2'd3; dut_ack = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    o = {dut_reset, dut_start, busy, result_valid, done, error, prog_sel, result_run, result_cycles};
    total++;
    if (o !== outs_t'('0)) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", o, outs_t'('0));
    end
    Reset = 1'b0; go = 1'b0; dut_ack = 1'b0;
    hSel = '0; hRun = '0; hCyc = '0; hErr = 1'b0;
  endtask

  task automatic test_single();
    build(0, '{10, 0, 0, 0}, 1'b0, 1'b0);
    play(2'd0, expQ.size());
    for (int c = 0; c < obsQ.size(); c++) begin
      total++;
      if (obsQ[c] !== expQ[c]) begin
        bad++;
        $display("FAIL single c=%0d: got %h want %h", c, obsQ[c], expQ[c]);
      end
    end
  endtask

  task automatic test_multi();
    build(2, '{5, 7, 3, 0}, 1'b0, 1'b1);
    play(2'd2, expQ.size());
    for (int c = 0; c < obsQ.size(); c++) begin
      total++;
      if (obsQ[c] !== expQ[c]) begin
        bad++;
        $display("FAIL multi c=%0d: got %h want %h", c, obsQ[c], expQ[c]);
      end
    end
  endtask

  task automatic test_timeout();
    build(3, '{30, 30, 30, 30}, 1'b0, 1'b1);
    play(2'd3, expQ.size());
    for (int c = 0; c < obsQ.size(); c++) begin
      total++;
      if (obsQ[c] !== expQ[c]) begin
        bad++;
        $display("FAIL timeout c=%0d: got %h want %h", c, obsQ[c], expQ[c]);
      end
    end
  endtask

  task automatic test_stale_ack();
    build(2, '{0, TMO, 3, 0}, 1'b1, 1'b1);
    play(2'd2, expQ.size());
    for (int c = 0; c < obsQ.size(); c++) begin
      total++;
      if (obsQ[c] !== expQ[c]) begin
        bad++;
        $display("FAIL stale_ack c=%0d: got %h want %h", c, obsQ[c], expQ[c]);
      end
    end
  endtask

  task automatic test_random();
    int       d [4];
    int       nr;
    for (int t = 0; t < 8; t++) begin
      nr = $urandom_range(0, 3);
      for (int k = 0; k < 4; k++) d[k] = $urandom_range(0, TMO + 4);
      build(nr, d, 1'($urandom), 1'b1);
      play(2'(nr), expQ.size());
      for (int c = 0; c < obsQ.size(); c++) begin
        total++;
        if (obsQ[c] !== expQ[c]) begin
          bad++;
          $display("FAIL random t=%0d c=%0d: got %h want %h", t, c, obsQ[c], expQ[c]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    outs_t o;
    build(3, '{15, 15, 15, 15}, 1'b0, 1'b1);
    play(2'd3, 1 + RST_CYC + START_CYC + 6);
    for (int c = 0; c < obsQ.size(); c++) begin
      total++;
      if (obsQ[c] !== expQ[c]) begin
        bad++;
        $display("FAIL midrun_pre c=%0d: got %h want %h", c, obsQ[c], expQ[c]);
      end
    end
    Reset = 1'b1; go = 1'b1; dut_ack = 1'b1;
    @(negedge Clk);
    o = {dut_reset, dut_start, busy, result_valid, done, error, prog_sel, result_run, result_cycles};
    total++;
    if (o !== outs_t'('0)) begin
      bad++;
      $display("FAIL midrun_reset: got %h want %h", o, outs_t'('0));
    end
    Reset = 1'b0; go = 1'b0; dut_ack = 1'b0;
    hSel = '0; hRun = '0; hCyc = '0; hErr = 1'b0;
    build(1, '{4, 9, 0, 0}, 1'b0, 1'b1);
    play(2'd1, expQ.size());
    for (int c = 0; c < obsQ.size(); c++) begin
      total++;
      if (obsQ[c] !== expQ[c]) begin
        bad++;
        $display("FAIL midrun_after c=%0d: got %h want %h", c, obsQ[c], expQ[c]);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; go = 1'b0; num_runs = '0; dut_ack = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_timeout();
    test_stale_ack();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
